// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: multi-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// and single-edge MTHI/MTLO writes. busy is high only while an operation is in flight.
module muldiv_unit #(
    parameter int MULT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'd32;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? neg32(v) : v;
    endfunction

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    logic        mul_sext;
    logic [63:0] mul_a, mul_b, prod;

    assign mul_sext = (op_q == OP_MULT);
    assign mul_a    = {{32{mul_sext & a_q[31]}}, a_q};
    assign mul_b    = {{32{mul_sext & b_q[31]}}, b_q};
    assign prod     = mul_a * mul_b;

    // One restoring step: shift next dividend bit into the partial remainder.
    logic [32:0] rem_sh;
    logic        take;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] div_hi, div_lo;

    assign rem_sh = {rem_q, quo_q[31]};
    assign take   = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx = take ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    assign quo_nx = {quo_q[30:0], take};

    always_comb begin
        div_hi = rem_nx;
        div_lo = quo_nx;
        if (dvs_q == 32'd0) begin
            div_hi = a_q;
            div_lo = 32'hFFFF_FFFF;
        end else if (op_q == OP_DIV) begin
            div_lo = (a_q[31] ^ b_q[31]) ? neg32(quo_nx) : quo_nx;
            div_hi = a_q[31] ? neg32(rem_nx) : rem_nx;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op;
                            cnt_d   = MUL_LOAD;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op;
                            cnt_d   = DIV_LOAD;
                            rem_d   = 32'd0;
                            quo_d   = (op == OP_DIV) ? abs32(a) : a;
                            dvs_d   = (op == OP_DIV) ? abs32(b) : b;
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q <= 6'd1) begin
                    {hi_d, lo_d} = prod;
                    cnt_d        = 6'd0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q <= 6'd1) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
